// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;
  localparam int PC_INC     = 4;

  // Default queue entry layout: instruction word above its fetch address.
  typedef struct packed {
    logic [FETCH_ILEN-1:0] inst;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO for fetched {inst, pc} pairs. There is no fall-through:
// a written entry is visible one cycle after the push. Flush empties the
// queue without clearing the storage array.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;

  // Next occupancy: a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push, pop})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
    end
  end

  // Entry storage, cleared on reset so the stale head reads as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: sequential PC generation, combinational imem read,
// and a decoupling queue towards decode. A redirect flushes the queue and
// restarts fetch at the word-aligned target.
// Optional: define FETCH_PERF_CNT_EN to add saturating perf_full_cycles and
// perf_flushes counters.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_full_cycles,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [CW-1:0]   count_s;
  logic            pop_s;
  logic            push_s;
  entry_t          wdata_s;
  entry_t          rdata_s;

  assign out_valid = (count_s != CW'(0));
  assign pop_s     = out_valid & out_ready;
  // A full queue can still accept a push when the head leaves this cycle.
  assign push_s    = ~redirect_valid & ((count_s < CW'(DEPTH)) | pop_s);
  assign wdata_s   = '{inst: imem_rdata, pc: pc_r};

  // Next PC: redirect target (word aligned), else advance on push, else hold.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_valid) begin
      pc_next_s = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push_s) begin
      pc_next_s = pc_r + XLEN'(PC_INC);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_r <= RESET_PC;
    else       pc_r <= pc_next_s;
  end

  assign imem_addr = pc_r;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s)
  );

  assign out_inst = rdata_s.inst;
  assign out_pc   = rdata_s.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_full_r;
  logic [31:0] perf_flush_r;
  logic        full_stall_s;

  assign full_stall_s = (count_s == CW'(DEPTH)) & ~pop_s;

  // Saturating counters for full-queue stall cycles and redirect cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_full_r  <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (full_stall_s && (perf_full_r != 32'hFFFF_FFFF))
        perf_full_r <= perf_full_r + 32'd1;
      if (redirect_valid && (perf_flush_r != 32'hFFFF_FFFF))
        perf_flush_r <= perf_flush_r + 32'd1;
    end
  end

  assign perf_full_cycles = perf_full_r;
  assign perf_flushes     = perf_flush_r;
`endif

endmodule
